sram_phy_ctrl: RTL

SRAM_PHY_CTRL -- requirements
Module: sram_phy_ctrl

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_phy_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM PHY controller.
package sram_pkg;

    localparam int RD_WAIT_DEF = 1;
    localparam int WR_WAIT_DEF = 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/sram_phy_ctrl.sv
// Single-port async SRAM controller: one master word access at a time, with
// registered strobes and configurable oe_n / we_n pulse widths.
module sram_phy_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       address,
    input  logic [31:0]       data_wr,
    input  logic              read_i,
    input  logic              write_i,
    output logic [31:0]       data_rd,
    output logic              stall_o,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [31:0]       sram_dq_i,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    state_t     state;
    logic [3:0] cnt;

    // Byte-offset and out-of-range address bits are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{address[31:ADDR_W+2], address[1:0]};

    // DONE is the only cycle a held request is released.
    assign stall_o   = (read_i | write_i) && (state != S_DONE);
    assign sram_be_n = {4{sram_ce_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= 32'd0;
            data_rd    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Write wins over a simultaneous read.
                    if (write_i) begin
                        sram_addr  <= address[ADDR_W+1:2];
                        sram_dq_o  <= data_wr;
                        sram_ce_n  <= 1'b0;
                        sram_dq_oe <= 1'b1;
                        state      <= S_WR_SETUP;
                    end else if (read_i) begin
                        sram_addr  <= address[ADDR_W+1:2];
                        sram_ce_n  <= 1'b0;
                        sram_oe_n  <= 1'b0;
                        cnt        <= 4'(RD_WAIT);
                        state      <= S_RD;
                    end
                end
                S_RD: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        data_rd   <= sram_dq_i;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    cnt       <= 4'(WR_WAIT - 1);
                    state     <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        sram_we_n <= 1'b1;
                        state     <= S_WR_HOLD;
                    end
                end
                S_WR_HOLD: begin
                    // Data stays driven one cycle past we_n for hold time.
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    state      <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
